// File: rtl/ls299_usr.sv
// ls299_usr -- parametrised universal storage/shift register with tri-state
// parallel output and a saturating shift counter.
//
// Parameters:
//   WIDTH      register width in bits (>= 2)
//   CNT_W      shift counter width, derived as $clog2(WIDTH+1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (q and counter to zero)
//   clr        synchronous clear, overrides the mode select
//   s          mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d_in       parallel load data
//   sr_in      serial input for right shift (enters the MSB)
//   sl_in      serial input for left shift (enters the LSB)
//   oe_n       active-low enable for d_out only
//   d_out      register contents, or all-Z when oe_n=1
//   q_lsb      q[0], always driven
//   q_msb      q[WIDTH-1], always driven
//   shift_cnt  shifts since the last load/clear, saturating at WIDTH
//   full       shift_cnt == WIDTH
module ls299_usr #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d_in,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic             oe_n,
  output wire  [WIDTH-1:0] d_out,
  output logic             q_lsb,
  output logic             q_msb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;

  // Counter increment that sticks at WIDTH instead of wrapping, so full
  // stays asserted while shifting continues.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      unique case (s)
        2'b11: begin
          q   <= d_in;
          cnt <= '0;
        end
        2'b01: begin
          q   <= {sr_in, q[WIDTH-1:1]};
          cnt <= sat_inc(cnt);
        end
        2'b10: begin
          q   <= {q[WIDTH-2:0], sl_in};
          cnt <= sat_inc(cnt);
        end
        default: begin
          q   <= q;
          cnt <= cnt;
        end
      endcase
    end
  end

  // Output enable gates only the parallel bus; serial taps stay live.
  assign d_out     = oe_n ? {WIDTH{1'bz}} : q;
  assign q_lsb     = q[0];
  assign q_msb     = q[WIDTH-1];
  assign shift_cnt = cnt;
  assign full      = (cnt == CNT_MAX);

endmodule

// File: tb/tb_ls299_usr.sv
// Testbench for ls299_usr: directed scenarios plus randomized traffic,
// scoreboarded against a behavioural model of the register.
module tb_ls299_usr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [1:0] s;
  logic [7:0] d_in;
  logic       sr_in, sl_in, oe_n;
  wire  [7:0] d_out;
  logic       q_lsb, q_msb, full;
  logic [3:0] shift_cnt;

  logic       clr4;
  logic [1:0] s4;
  logic [3:0] d_in4;
  logic       sr4, sl4, oe4;
  wire  [3:0] d_out4;
  logic       q_lsb4, q_msb4, full4;
  logic [2:0] shift_cnt4;

  always #5 clk = ~clk;

  ls299_usr #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(s), .d_in(d_in),
    .sr_in(sr_in), .sl_in(sl_in), .oe_n(oe_n), .d_out(d_out),
    .q_lsb(q_lsb), .q_msb(q_msb), .shift_cnt(shift_cnt), .full(full)
  );

  ls299_usr #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .s(s4), .d_in(d_in4),
    .sr_in(sr4), .sl_in(sl4), .oe_n(oe4), .d_out(d_out4),
    .q_lsb(q_lsb4), .q_msb(q_msb4), .shift_cnt(shift_cnt4), .full(full4)
  );

  typedef struct {
    logic [7:0] q;
    int         cnt;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] m_q;
  int         m_cnt;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the register as a number, shifts as arithmetic, the
  // counter as min(count, width).
  task automatic step(input logic c, input logic [1:0] ss, input logic [7:0] d,
                      input logic sr, input logic sl, input logic oe);
    clr = c; s = ss; d_in = d; sr_in = sr; sl_in = sl; oe_n = oe;
    if (c) begin
      m_q = 8'h00; m_cnt = 0;
    end else if (ss == 2'b11) begin
      m_q = d; m_cnt = 0;
    end else if (ss == 2'b01) begin
      m_q = (m_q >> 1) + (sr ? 8'd128 : 8'd0);
      m_cnt = (m_cnt + 1 > 8) ? 8 : m_cnt + 1;
    end else if (ss == 2'b10) begin
      m_q = 8'((m_q * 2) % 256) + (sl ? 8'd1 : 8'd0);
      m_cnt = (m_cnt + 1 > 8) ? 8 : m_cnt + 1;
    end
    sbq.push_back('{q: m_q, cnt: m_cnt});
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; s = 2'b00;
  endtask

  // Monitor: every edge that had stimulus issued is checked after it settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_q_lsb", 32'(q_lsb), 32'(e.q[0]));
        chk("sb_q_msb", 32'(q_msb), 32'(e.q[7]));
        chk("sb_shift_cnt", 32'(shift_cnt), 32'(e.cnt));
        chk("sb_full", 32'(full), 32'(e.cnt == 8));
        if (!oe_n) begin
          chk("sb_d_out", 32'(d_out), 32'(e.q));
        end else if (e.q != 8'h00) begin
          n_tests++;
          if (d_out === e.q) begin
            n_fail++;
            $display("FAIL sb_d_out_disabled: got %h while oe_n=1, required Z", d_out);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] ser_seq;
    rst_n = 1'b0; clr = 1'b0; s = 2'b00; d_in = 8'h00;
    sr_in = 1'b0; sl_in = 1'b0; oe_n = 1'b0;
    clr4 = 1'b0; s4 = 2'b00; d_in4 = 4'h0; sr4 = 1'b0; sl4 = 1'b0; oe4 = 1'b0;
    m_q = 8'h00; m_cnt = 0;
    repeat (2) @(negedge clk);
    chk("rst_d_out", 32'(d_out), 32'h00);
    chk("rst_shift_cnt", 32'(shift_cnt), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_q_lsb_msb", 32'({q_msb, q_lsb}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-cycle with q=3C.
    step(1'b0, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_d_out", 32'(d_out), 32'h3C);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_d_out", 32'(d_out), 32'h00);
    chk("async_rst_cnt", 32'(shift_cnt), 0);
    chk("async_rst_full", 32'(full), 0);
    m_q = 8'h00; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load and output enable.
    step(1'b0, 2'b11, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("load_d_out", 32'(d_out), 32'hAA);
    chk("load_cnt", 32'(shift_cnt), 0);
    oe_n = 1'b1;
    #1;
    n_tests++;
    if (d_out === 8'hAA) begin
      n_fail++;
      $display("FAIL oe_disable: got %h while oe_n=1, required Z", d_out);
    end
    chk("oe_q_msb", 32'(q_msb), 1);
    chk("oe_q_lsb", 32'(q_lsb), 0);
    oe_n = 1'b0;
    #1;
    chk("oe_reenable", 32'(d_out), 32'hAA);

    // Shift-right fill from zero, then one saturating shift.
    step(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fill_d_out", 32'(d_out), 32'hFF);
    chk("fill_cnt", 32'(shift_cnt), 8);
    chk("fill_full", 32'(full), 1);
    step(1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("sat_d_out", 32'(d_out), 32'hFF);
    chk("sat_cnt", 32'(shift_cnt), 8);

    // Reset while full: full must drop without a clock.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_full_drop", 32'(full), 0);
    chk("rst_full_cnt", 32'(shift_cnt), 0);
    m_q = 8'h00; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Shift-left serialise of 81.
    ser_seq = 8'b1000_0001;
    step(1'b0, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("ser_q_msb", 32'(q_msb), 32'(ser_seq[7-i]));
      step(1'b0, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("ser_end_q", 32'(d_out), 32'h00);

    // Priority: clr beats load.
    step(1'b0, 2'b11, 8'hF0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("clr_prio", 32'(d_out), 32'h00);
    step(1'b0, 2'b11, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rshift_q", 32'(d_out), 32'h2A);
    chk("rshift_cnt", 32'(shift_cnt), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 8'hC3, 1'b1, 1'b1, 1'b0);
    chk("hold_q", 32'(d_out), 32'h2A);
    chk("hold_cnt", 32'(shift_cnt), 1);

    // WIDTH=4 instance.
    s4 = 2'b11; d_in4 = 4'h9;
    @(posedge clk); @(negedge clk);
    chk("w4_load", 32'(d_out4), 32'h9);
    s4 = 2'b01; sr4 = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    s4 = 2'b00;
    chk("w4_q", 32'(d_out4), 32'h0);
    chk("w4_cnt", 32'(shift_cnt4), 4);
    chk("w4_full", 32'(full4), 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(posedge clk);
    #2;
    chk("sb_drain", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
